// File: rtl/imem_uart_loader.sv
// UART boot loader: frames SYNC,LEN_HI,LEN_LO,data,CHK into instruction RAM words.
// Holds the CPU in reset until a frame with a matching XOR checksum has loaded.
module imem_uart_loader #(
    parameter int unsigned MAX_WORDS      = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        reload,
    output logic        mem_we,
    output logic [30:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] word_cnt
);

    localparam logic [15:0] MaxW = 16'(MAX_WORDS);
    localparam logic [31:0] Tmo  = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  chk_q, chk_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic        we_q, we_d;
    logic [30:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] tmo_q, tmo_d;

    logic        active;
    logic [15:0] len_full;
    logic [31:0] word_next;
    logic [15:0] cnt_next;

    assign active    = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                       (state_q == S_DATA)   || (state_q == S_CHECK);
    assign len_full  = {len_q[15:8], rx_data};
    assign word_next = {word_q[23:0], rx_data};
    assign cnt_next  = cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        chk_d   = chk_q;
        word_d  = word_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tmo_d   = 32'd0;

        if (active && !rx_valid) begin
            tmo_d = tmo_q + 32'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    len_d   = {rx_data, len_q[7:0]};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    len_d = len_full;
                    cnt_d = 16'd0;
                    chk_d = 8'd0;
                    idx_d = 2'd0;
                    if (len_full == 16'd0) begin
                        state_d = S_CHECK;
                    end else if (len_full > MaxW) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    word_d = word_next;
                    chk_d  = chk_q ^ rx_data;
                    idx_d  = idx_q + 2'd1;
                    // Write is registered so it lands the cycle after the 4th byte
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = {13'b0, cnt_q, 2'b00};
                        wdata_d = word_next;
                        cnt_d   = cnt_next;
                        if (cnt_next == len_q) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (rx_valid) begin
                    state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (reload) begin
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (active && !rx_valid && (tmo_q + 32'd1 >= Tmo)) begin
            state_d = S_ERR;
            tmo_d   = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= 16'd0;
            cnt_q   <= 16'd0;
            chk_q   <= 8'd0;
            word_q  <= 32'd0;
            idx_q   <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= 31'd0;
            wdata_q <= 32'd0;
            tmo_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign word_cnt  = cnt_q;
    assign cpu_hold  = (state_q != S_DONE);
    assign load_done = (state_q == S_DONE);
    assign load_err  = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: directed frames, RAM writes checked
// against a queue of expected (addr, data) pairs by a negedge monitor.
module tb_imem_uart_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        reload;
    logic        mem_we;
    logic [30:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [15:0] word_cnt;

    int checks = 0;
    int errors = 0;

    logic [62:0] exp_q[$];

    imem_uart_loader #(
        .MAX_WORDS(256),
        .TIMEOUT_CYCLES(100),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .reload(reload),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold),
        .load_done(load_done),
        .load_err(load_err),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && mem_we) begin
            logic [62:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                             mem_addr, mem_wdata, e[62:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Called #1 after a posedge; leaves us #1 after the sampling edge
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic exp_wr(input logic [30:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic frame1(input logic [7:0] c);
        logic [7:0] f[8];
        f = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h10, 8'h40, 8'h00};
        exp_wr(31'h0, 32'h00000000);
        exp_wr(31'h4, 32'h3C104000);
        send(8'hA5);
        send(8'h00);
        send(8'h02);
        for (int i = 0; i < 8; i++) send(f[i]);
        send(c);
    endtask

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        reload   = 1'b0;
        idle(3);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wcnt", 32'(word_cnt), 32'd0);
        reset = 1'b0;
        idle(2);

        // 1: good two-word frame
        frame1(8'h6C);
        idle(2);
        chk("t1_done", 32'(load_done), 32'd1);
        chk("t1_hold", 32'(cpu_hold), 32'd0);
        chk("t1_err", 32'(load_err), 32'd0);
        chk("t1_wcnt", 32'(word_cnt), 32'd2);
        send(8'hA5);
        send(8'h12);
        idle(2);
        chk("t1_ignore", 32'(load_done), 32'd1);
        pulse_reload();
        chk("t1_rl_hold", 32'(cpu_hold), 32'd1);
        chk("t1_rl_done", 32'(load_done), 32'd0);
        chk("t1_rl_wcnt", 32'(word_cnt), 32'd0);

        // 2: bad checksum
        frame1(8'h00);
        idle(2);
        chk("t2_err", 32'(load_err), 32'd1);
        chk("t2_hold", 32'(cpu_hold), 32'd1);
        chk("t2_done", 32'(load_done), 32'd0);
        pulse_reload();
        chk("t2_rl_err", 32'(load_err), 32'd0);

        // 3: junk then empty frame
        send(8'h11);
        send(8'h22);
        send(8'hA5);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        idle(2);
        chk("t3_done", 32'(load_done), 32'd1);
        chk("t3_wcnt", 32'(word_cnt), 32'd0);
        // reload beats a simultaneous byte
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        reload   = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        reload   = 1'b0;
        chk("t3_rl_hold", 32'(cpu_hold), 32'd1);
        send(8'hA5);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        idle(2);
        chk("t3_rl_done", 32'(load_done), 32'd1);
        pulse_reload();

        // 4: length too large
        send(8'hA5);
        send(8'h01);
        send(8'h01);
        for (int i = 0; i < 6; i++) send(8'h00);
        idle(2);
        chk("t4_err", 32'(load_err), 32'd1);
        chk("t4_hold", 32'(cpu_hold), 32'd1);
        pulse_reload();

        // 5: timeout mid-DATA
        send(8'hA5);
        send(8'h00);
        send(8'h01);
        send(8'h12);
        idle(95);
        chk("t5_pre_err", 32'(load_err), 32'd0);
        idle(10);
        chk("t5_err", 32'(load_err), 32'd1);
        pulse_reload();

        // 6: reset mid-DATA, reload, rewrite from 0
        send(8'hA5);
        send(8'h00);
        send(8'h02);
        send(8'h00);
        send(8'h00);
        reset = 1'b1;
        #1;
        chk("t6_rst_hold", 32'(cpu_hold), 32'd1);
        chk("t6_rst_wcnt", 32'(word_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        frame1(8'h6C);
        idle(2);
        chk("t6_done", 32'(load_done), 32'd1);
        pulse_reload();
        chk("t6_rl_hold", 32'(cpu_hold), 32'd1);
        exp_wr(31'h0, 32'hDEADBEEF);
        send(8'hA5);
        send(8'h00);
        send(8'h01);
        send(8'hDE);
        send(8'hAD);
        send(8'hBE);
        send(8'hEF);
        send(8'h22);
        idle(2);
        chk("t6_done2", 32'(load_done), 32'd1);
        chk("t6_wcnt2", 32'(word_cnt), 32'd1);

        idle(3);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
